// File: rtl/exe_mem_skid_reg_if.sv
// Handshake and payload bundle between the EXE stage, the EXE/MEM skid register and the memory stage.
// The slave modport is the register's view; the master modport is the surrounding pipeline's view.
interface exe_mem_skid_reg_if #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              WB_EN_in;
  logic              MEM_R_EN_in;
  logic              MEM_W_EN_in;
  logic [DATA_W-1:0] ALU_res_in;
  logic [DATA_W-1:0] ST_value_in;
  logic [DEST_W-1:0] Dest_in;
  logic              out_valid;
  logic              out_ready;
  logic              WB_EN;
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic [DATA_W-1:0] ALU_res;
  logic [DATA_W-1:0] ST_value;
  logic [DEST_W-1:0] Dest;
  logic [1:0]        occupancy;

  modport slave (
    input  in_valid, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, ALU_res_in, ST_value_in, Dest_in,
    input  out_ready,
    output in_ready, out_valid, WB_EN, MEM_R_EN, MEM_W_EN, ALU_res, ST_value, Dest, occupancy
  );

  modport master (
    output in_valid, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, ALU_res_in, ST_value_in, Dest_in,
    output out_ready,
    input  in_ready, out_valid, WB_EN, MEM_R_EN, MEM_W_EN, ALU_res, ST_value, Dest, occupancy
  );
endinterface

// File: rtl/exe_mem_skid_reg.sv
// EXE/MEM pipeline register with a one-entry skid buffer: full throughput, registered in_ready,
// in-order delivery and a synchronous flush that discards everything held.
module exe_mem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  exe_mem_skid_reg_if.slave   bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic              wb;
    logic              memR;
    logic              memW;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] st;
    logic [DEST_W-1:0] dest;
  } entry_t;

  state_t r_state;
  logic   r_inReady;
  entry_t r_main;
  entry_t r_skid;

  logic   w_outValid;
  logic   w_inFire;
  logic   w_outFire;
  entry_t w_inPkt;

  assign w_outValid = (r_state != EMPTY);
  assign w_inFire   = bus.in_valid & r_inReady;
  assign w_outFire  = w_outValid & bus.out_ready;

  // A packet that is both load and store is kept as a store only.
  assign w_inPkt.wb   = bus.WB_EN_in;
  assign w_inPkt.memR = bus.MEM_R_EN_in & ~bus.MEM_W_EN_in;
  assign w_inPkt.memW = bus.MEM_W_EN_in;
  assign w_inPkt.alu  = bus.ALU_res_in;
  assign w_inPkt.st   = bus.ST_value_in;
  assign w_inPkt.dest = bus.Dest_in;

  // in_ready is computed from the next state so the EXE stage never sees a combinational path from out_ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= EMPTY;
      r_inReady <= 1'b1;
      r_main    <= '0;
      r_skid    <= '0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_inReady   <= 1'b1;
      r_main.wb   <= 1'b0;
      r_main.memR <= 1'b0;
      r_main.memW <= 1'b0;
      r_skid.wb   <= 1'b0;
      r_skid.memR <= 1'b0;
      r_skid.memW <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_inFire) begin
            r_main  <= w_inPkt;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_inFire && w_outFire) begin
            r_main <= w_inPkt;
          end else if (w_inFire) begin
            r_skid    <= w_inPkt;
            r_state   <= TWO;
            r_inReady <= 1'b0;
          end else if (w_outFire) begin
            r_state <= EMPTY;
          end
        end
        TWO: begin
          if (w_outFire) begin
            r_main    <= r_skid;
            r_state   <= ONE;
            r_inReady <= 1'b1;
          end
        end
        default: begin
          r_state   <= EMPTY;
          r_inReady <= 1'b1;
        end
      endcase
    end
  end

  // Payload holds its last value when empty; only the enables are masked.
  assign bus.out_valid = w_outValid;
  assign bus.in_ready  = r_inReady;
  assign bus.occupancy = r_state;
  assign bus.WB_EN     = r_main.wb   & w_outValid;
  assign bus.MEM_R_EN  = r_main.memR & w_outValid;
  assign bus.MEM_W_EN  = r_main.memW & w_outValid;
  assign bus.ALU_res   = r_main.alu;
  assign bus.ST_value  = r_main.st;
  assign bus.Dest      = r_main.dest;

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Self-checking bench for exe_mem_skid_reg: a directed vector table, hand-written reset sequences and
// random traffic, all compared against a queue-based model of a two-deep in-order buffer.
module tb_exe_mem_skid_reg;

  localparam int DATA_W = 32;
  localparam int DEST_W = 5;

  typedef struct packed {
    logic              wb;
    logic              mr;
    logic              mw;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] st;
    logic [DEST_W-1:0] dest;
  } pkt_t;

  typedef struct {
    logic              iv;
    logic              orr;
    logic              fl;
    logic              wb;
    logic              mr;
    logic              mw;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] st;
    logic              expValid;
    logic              expIr;
    logic [1:0]        expOcc;
    logic              expWB;
    logic              expMR;
    logic              expMW;
    logic [DEST_W-1:0] expDest;
  } vec_t;

  logic clock;
  logic reset;
  logic flush;
  int   errors;
  int   checks;

  pkt_t q[$];
  pkt_t shown;
  vec_t tbl[$];

  exe_mem_skid_reg_if #(.DATA_W(DATA_W), .DEST_W(DEST_W)) bus ();

  exe_mem_skid_reg #(.DATA_W(DATA_W), .DEST_W(DEST_W)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [75:0] dutVec();
    return {bus.out_valid, bus.in_ready, bus.occupancy, bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN,
            bus.ALU_res, bus.ST_value, bus.Dest};
  endfunction

  // The model is just an ordered list of at most two packets plus the last packet that was at the head.
  function automatic logic [75:0] modelVec();
    logic v;
    v = (q.size() != 0);
    return {v, (q.size() < 2), 2'(q.size()), shown.wb & v, shown.mr & v, shown.mw & v,
            shown.alu, shown.st, shown.dest};
  endfunction

  task automatic checkOutput(input string name);
    checks++;
    if (dutVec() !== modelVec()) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, dutVec(), modelVec());
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic orr, input logic fl, input pkt_t p);
    logic inFire;
    logic outFire;
    pkt_t stored;
    bus.in_valid    = iv;
    bus.out_ready   = orr;
    flush           = fl;
    bus.WB_EN_in    = p.wb;
    bus.MEM_R_EN_in = p.mr;
    bus.MEM_W_EN_in = p.mw;
    bus.ALU_res_in  = p.alu;
    bus.ST_value_in = p.st;
    bus.Dest_in     = p.dest;
    inFire  = iv && (q.size() < 2);
    outFire = orr && (q.size() != 0);
    stored  = p;
    stored.mr = p.mr & ~p.mw;
    @(posedge clock);
    if (fl) begin
      q.delete();
    end else begin
      if (outFire) void'(q.pop_front());
      if (inFire) q.push_back(stored);
    end
    if (q.size() != 0) shown = q[0];
    @(negedge clock);
  endtask

  function automatic vec_t mk(input logic iv, input logic orr, input logic fl, input logic wb,
                              input logic mr, input logic mw, input int dest,
                              input logic ev, input logic eir, input int eocc,
                              input logic ewb, input logic emr, input logic emw, input int edest);
    vec_t v;
    v.iv = iv; v.orr = orr; v.fl = fl; v.wb = wb; v.mr = mr; v.mw = mw;
    v.dest = DEST_W'(dest);
    v.st = 32'hC0DE_0000 | 32'(dest);
    v.expValid = ev; v.expIr = eir; v.expOcc = 2'(eocc);
    v.expWB = ewb; v.expMR = emr; v.expMW = emw; v.expDest = DEST_W'(edest);
    return v;
  endfunction

  function automatic pkt_t rowPkt(input vec_t v);
    pkt_t p;
    p.wb = v.wb; p.mr = v.mr; p.mw = v.mw;
    p.alu = {23'd0, v.dest, 4'h0};
    p.st = v.st;
    p.dest = v.dest;
    return p;
  endfunction

  initial begin
    pkt_t p;
    logic [16:0] got;
    logic [16:0] exp;
    vec_t r;
    errors = 0;
    checks = 0;
    shown  = '0;
    reset  = 1'b1;
    flush  = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.WB_EN_in = 1'b0; bus.MEM_R_EN_in = 1'b0; bus.MEM_W_EN_in = 1'b0;
    bus.ALU_res_in = '0; bus.ST_value_in = '0; bus.Dest_in = '0;
    repeat (2) @(negedge clock);
    checkOutput("resetState");
    reset = 1'b0;

    // Directed vectors: iv orr fl wb mr mw dest | valid ir occ WB MR MW dest
    r = mk(1,1,0, 0,0,1, 1,   1,1,1, 0,0,1, 1); r.st = 32'h0000_DEAD; tbl.push_back(r);
    tbl.push_back(mk(0,1,0, 0,0,0, 0,   0,1,0, 0,0,0, 1));
    tbl.push_back(mk(1,0,0, 1,0,0, 3,   1,1,1, 1,0,0, 3));
    tbl.push_back(mk(1,0,0, 1,0,0, 4,   1,0,2, 1,0,0, 3));
    tbl.push_back(mk(1,0,0, 1,0,1, 7,   1,0,2, 1,0,0, 3));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,   1,1,1, 1,0,0, 4));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,   0,1,0, 0,0,0, 4));
    tbl.push_back(mk(1,0,0, 1,0,0, 5,   1,1,1, 1,0,0, 5));
    tbl.push_back(mk(1,0,0, 0,1,0, 6,   1,0,2, 1,0,0, 5));
    tbl.push_back(mk(1,0,1, 1,0,1, 9,   0,1,0, 0,0,0, 5));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,   0,1,0, 0,0,0, 5));
    tbl.push_back(mk(1,1,0, 0,1,1, 10,  1,1,1, 0,0,1, 10));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,   0,1,0, 0,0,0, 10));
    for (int k = 1; k <= 8; k++) tbl.push_back(mk(1,1,0, 1,0,0, k,  1,1,1, 1,0,0, k));
    tbl.push_back(mk(0,1,0, 0,0,0, 0,   0,1,0, 0,0,0, 8));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].iv, tbl[i].orr, tbl[i].fl, rowPkt(tbl[i]));
      got = {bus.out_valid, bus.in_ready, bus.occupancy, bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN,
             bus.Dest, bus.ALU_res[7:0]};
      exp = {tbl[i].expValid, tbl[i].expIr, tbl[i].expOcc, tbl[i].expWB, tbl[i].expMR, tbl[i].expMW,
             tbl[i].expDest, tbl[i].expDest, 3'b000};
      exp[7:0] = {tbl[i].expDest[3:0], 4'h0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL tbl[%0d]: got %h expected %h", i, got, exp);
      end
      checkOutput($sformatf("model[%0d]", i));
    end

    // Fill both entries, then hit reset between clock edges and look before the next edge.
    p = '0; p.wb = 1'b1; p.mw = 1'b1; p.alu = 32'h40; p.st = 32'h1234; p.dest = 5'd11;
    applyStimulus(1'b1, 1'b0, 1'b0, p);
    p.dest = 5'd12;
    applyStimulus(1'b1, 1'b0, 1'b0, p);
    checkOutput("twoBeforeReset");
    bus.in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    q.delete();
    shown = '0;
    checkOutput("midReset");
    #2 reset = 1'b0;
    @(negedge clock);
    checkOutput("afterRelease");
    p = '0; p.mr = 1'b1; p.wb = 1'b1; p.alu = 32'h80; p.st = 32'h5; p.dest = 5'd13;
    applyStimulus(1'b1, 1'b1, 1'b0, p);
    checkOutput("postResetLatency");
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("postResetDrain");

    for (int n = 0; n < 500; n++) begin
      p.wb   = 1'($urandom);
      p.mr   = 1'($urandom);
      p.mw   = 1'($urandom);
      p.alu  = $urandom;
      p.st   = $urandom;
      p.dest = DEST_W'($urandom_range(0, 31));
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 15) == 0, p);
      checkOutput($sformatf("random[%0d]", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
